// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front end. It issues one sequential fetch request at a
// time to the instruction cache/memory and buffers the returned
// {PC, instruction} pairs in a small FIFO for the decoder. A control-transfer
// instruction (bit 6 set) halts fetching until the jump or branch unit
// redirects the PC. A request that is still in flight when a redirect arrives
// is allowed to complete, and its data is dropped.
//
// Optional feature:
//   FETCH_BYPASS_EN - when defined, a response that arrives while the queue
//                     is empty, the decoder is ready and there is no redirect
//                     goes straight to the decoder in the same cycle and is
//                     not enqueued. When undefined, every response is
//                     enqueued, so DecEn rises at the earliest one cycle
//                     after the response.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   stall                 decoder does not accept the head this cycle
//   enJump / JumpAddr     jump redirect (has priority over the branch)
//   enBranch / BranchAddr branch redirect
//   DecEn/DecPC/DecInst   queue head presented to the decoder
//   instEn / instAddr     outstanding fetch request (level) and its address
//   hit / cacheInst       cache response for the outstanding request
//   memInstOutEn/memInst  memory response (used only when hit is low)
//
// state   | meaning
// IDLE    | first cycle after reset; RESET_PC is issued on the next edge
// RUN     | sequential fetching
// WAIT_BJ | a jump/branch instruction was queued; fetch halts until redirect
// DISCARD | redirected with a request in flight; drop its response, then
//         | fetch the saved target
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                QDEPTH   = 4,
  parameter int                PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              enJump,
  input  logic [ADDR_W-1:0] JumpAddr,
  input  logic              enBranch,
  input  logic [ADDR_W-1:0] BranchAddr,
  output logic              DecEn,
  output logic [ADDR_W-1:0] DecPC,
  output logic [INST_W-1:0] DecInst,
  output logic              instEn,
  output logic [ADDR_W-1:0] instAddr,
  input  logic              hit,
  input  logic [INST_W-1:0] cacheInst,
  input  logic              memInstOutEn,
  input  logic [INST_W-1:0] memInst
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    WAIT_BJ = 2'd2,
    DISCARD = 2'd3
  } state_e;

  state_e            state_q;
  logic              inst_en_q;
  logic [ADDR_W-1:0] inst_addr_q;
  logic [ADDR_W-1:0] target_q;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [ADDR_W-1:0] pc_mem_q   [QDEPTH];
  logic [INST_W-1:0] inst_mem_q [QDEPTH];

  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              resp_v;
  logic [INST_W-1:0] resp_inst;
  logic              head_v;
  logic              deq;
  logic              run_resp;
  logic              bypass;
  logic              enq;
  logic              can_issue;
  logic [ADDR_W-1:0] seq_addr;

  assign redirect      = enJump | enBranch;
  assign redirect_addr = enJump ? JumpAddr : BranchAddr;

  // A response only counts while a request is actually outstanding.
  assign resp_v    = inst_en_q & (hit | memInstOutEn);
  assign resp_inst = hit ? cacheInst : memInst;

  assign head_v = (count_q != '0);
  assign deq    = head_v & ~stall;

  // Responses are only kept in RUN; a same-cycle redirect flushes them.
  assign run_resp = (state_q == RUN) & resp_v & ~redirect;

`ifdef FETCH_BYPASS_EN
  assign bypass = run_resp & ~head_v & ~stall;
`else
  assign bypass = 1'b0;
`endif

  assign enq = run_resp & ~bypass & ((count_q != FULL_CNT) | deq);

  always_comb begin
    count_d = count_q;
    if (redirect) begin
      count_d = '0;
    end else begin
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Issuing only when the post-edge count leaves room guarantees that the
  // response always has a free slot, so the full-queue enqueue guard never
  // actually drops data.
  assign can_issue = (count_d < FULL_CNT);
  assign seq_addr  = inst_addr_q + ADDR_W'(PC_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      inst_en_q   <= 1'b0;
      inst_addr_q <= RESET_PC;
      target_q    <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          state_q     <= RUN;
          inst_en_q   <= 1'b1;
          inst_addr_q <= redirect ? redirect_addr : RESET_PC;
        end
        RUN: begin
          if (redirect) begin
            if (inst_en_q && !resp_v) begin
              // Request still in flight: keep instEn up until it lands.
              state_q  <= DISCARD;
              target_q <= redirect_addr;
            end else begin
              inst_en_q   <= 1'b1;
              inst_addr_q <= redirect_addr;
            end
          end else if (resp_v) begin
            if (resp_inst[6]) begin
              state_q   <= WAIT_BJ;
              inst_en_q <= 1'b0;
            end else if (can_issue) begin
              inst_addr_q <= seq_addr;
            end else begin
              inst_en_q <= 1'b0;
            end
          end else if (!inst_en_q && can_issue) begin
            inst_en_q   <= 1'b1;
            inst_addr_q <= seq_addr;
          end
        end
        WAIT_BJ: begin
          if (redirect) begin
            state_q     <= RUN;
            inst_en_q   <= 1'b1;
            inst_addr_q <= redirect_addr;
          end
        end
        DISCARD: begin
          if (redirect) begin
            target_q <= redirect_addr;
          end
          if (resp_v) begin
            state_q     <= RUN;
            inst_en_q   <= 1'b1;
            inst_addr_q <= redirect ? redirect_addr : target_q;
          end
        end
        default: begin
          state_q   <= IDLE;
          inst_en_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (enq) begin
          wr_ptr_q <= wr_ptr_q + PTR_ONE;
        end
        if (deq) begin
          rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
      end
    end
  end

  // Storage needs no reset: the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem_q[wr_ptr_q]   <= inst_addr_q;
      inst_mem_q[wr_ptr_q] <= resp_inst;
    end
  end

  always_comb begin
    DecEn   = head_v;
    DecPC   = head_v ? pc_mem_q[rd_ptr_q]   : '0;
    DecInst = head_v ? inst_mem_q[rd_ptr_q] : '0;
`ifdef FETCH_BYPASS_EN
    if (bypass) begin
      DecEn   = 1'b1;
      DecPC   = inst_addr_q;
      DecInst = resp_inst;
    end
`endif
  end

  assign instEn   = inst_en_q;
  assign instAddr = inst_addr_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        enJump;
  logic [31:0] JumpAddr;
  logic        enBranch;
  logic [31:0] BranchAddr;
  logic        DecEn;
  logic [31:0] DecPC;
  logic [31:0] DecInst;
  logic        instEn;
  logic [31:0] instAddr;
  logic        hit;
  logic [31:0] cacheInst;
  logic        memInstOutEn;
  logic [31:0] memInst;

  int          errors = 0;
  int          checks = 0;
  int          resp_mode = 0;
  logic [31:0] bj_pc = 32'hFFFF_FFF0;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .enJump       (enJump),
    .JumpAddr     (JumpAddr),
    .enBranch     (enBranch),
    .BranchAddr   (BranchAddr),
    .DecEn        (DecEn),
    .DecPC        (DecPC),
    .DecInst      (DecInst),
    .instEn       (instEn),
    .instAddr     (instAddr),
    .hit          (hit),
    .cacheInst    (cacheInst),
    .memInstOutEn (memInstOutEn),
    .memInst      (memInst)
  );

  // Cache contents: a non-branch word tagged with its PC, except at bj_pc.
  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    if (pc == bj_pc) return 32'h0000_006F;
    return (pc << 8) | 32'h0000_0013;
  endfunction

  task automatic drive_resp();
    hit       = 1'b0;
    cacheInst = '0;
    if (resp_mode == 1 && instEn) begin
      hit       = 1'b1;
      cacheInst = mk_inst(instAddr);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    drive_resp();
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; enJump = 1'b0; enBranch = 1'b0;
    JumpAddr = '0; BranchAddr = '0; hit = 1'b0; cacheInst = '0;
    memInstOutEn = 1'b0; memInst = '0; resp_mode = 0; bj_pc = 32'hFFFF_FFF0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    resp_mode = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; enJump = 1'b0; enBranch = 1'b0;
    JumpAddr = '0; BranchAddr = '0; hit = 1'b0; cacheInst = '0;
    memInstOutEn = 1'b0; memInst = '0;
    #1;
    checks++; if (instEn !== 1'b0) begin errors++; $display("FAIL reset_instEn: got %b expected 0", instEn); end
    checks++; if (instAddr !== 32'h0) begin errors++; $display("FAIL reset_instAddr: got %h expected 00000000", instAddr); end
    checks++; if (DecEn !== 1'b0) begin errors++; $display("FAIL reset_DecEn: got %b expected 0", DecEn); end
    checks++; if (DecPC !== 32'h0) begin errors++; $display("FAIL reset_DecPC: got %h expected 00000000", DecPC); end
    checks++; if (DecInst !== 32'h0) begin errors++; $display("FAIL reset_DecInst: got %h expected 00000000", DecInst); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (instEn !== 1'b0) begin errors++; $display("FAIL reset_held_instEn: got %b expected 0", instEn); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    do_reset();
    tick();
    checks++; if (instEn !== 1'b1) begin errors++; $display("FAIL seq_first_instEn: got %b expected 1", instEn); end
    checks++; if (instAddr !== 32'h0) begin errors++; $display("FAIL seq_first_addr: got %h expected 00000000", instAddr); end
    checks++; if (DecEn !== 1'b0) begin errors++; $display("FAIL seq_first_DecEn: got %b expected 0", DecEn); end
    for (int k = 2; k <= 9; k++) begin
      tick();
      exp_pc = 32'(4 * (k - 2));
      checks++; if (instAddr !== 32'(4 * (k - 1))) begin errors++; $display("FAIL seq_addr k=%0d: got %h expected %h", k, instAddr, 32'(4 * (k - 1))); end
      checks++; if (DecEn !== 1'b1) begin errors++; $display("FAIL seq_DecEn k=%0d: got %b expected 1", k, DecEn); end
      checks++; if (DecPC !== exp_pc) begin errors++; $display("FAIL seq_DecPC k=%0d: got %h expected %h", k, DecPC, exp_pc); end
      checks++; if (DecInst !== mk_inst(exp_pc)) begin errors++; $display("FAIL seq_DecInst k=%0d: got %h expected %h", k, DecInst, mk_inst(exp_pc)); end
    end
  endtask

  task automatic test_hit_priority();
    do_reset();
    resp_mode = 0;
    tick();
    hit = 1'b1; cacheInst = 32'hAAAA_0013;
    memInstOutEn = 1'b1; memInst = 32'h5555_0093;
    tick();
    memInstOutEn = 1'b0;
    checks++; if (DecInst !== 32'hAAAA_0013) begin errors++; $display("FAIL prio_hit_inst: got %h expected aaaa0013", DecInst); end
    checks++; if (instAddr !== 32'h4) begin errors++; $display("FAIL prio_next_addr: got %h expected 00000004", instAddr); end
    memInstOutEn = 1'b1; memInst = 32'h5555_0093;
    tick();
    memInstOutEn = 1'b0;
    checks++; if (DecPC !== 32'h4) begin errors++; $display("FAIL mem_DecPC: got %h expected 00000004", DecPC); end
    checks++; if (DecInst !== 32'h5555_0093) begin errors++; $display("FAIL mem_DecInst: got %h expected 55550093", DecInst); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    do_reset();
    tick(); tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) begin
        checks++; if (instEn !== 1'b0) begin errors++; $display("FAIL stall_full_instEn: got %b expected 0", instEn); end
      end
    end
    checks++; if (instEn !== 1'b0) begin errors++; $display("FAIL stall_end_instEn: got %b expected 0", instEn); end
    checks++; if (DecEn !== 1'b1) begin errors++; $display("FAIL stall_DecEn: got %b expected 1", DecEn); end
    checks++; if (DecPC !== 32'h4) begin errors++; $display("FAIL stall_head: got %h expected 00000004", DecPC); end
    stall = 1'b0;
    tick();
    checks++; if (instEn !== 1'b1) begin errors++; $display("FAIL release_instEn: got %b expected 1", instEn); end
    checks++; if (instAddr !== 32'h14) begin errors++; $display("FAIL release_addr: got %h expected 00000014", instAddr); end
    exp_pc = 32'h8;
    checks++; if (DecPC !== exp_pc) begin errors++; $display("FAIL release_DecPC: got %h expected %h", DecPC, exp_pc); end
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_pc = exp_pc + 32'h4;
      checks++; if (DecPC !== exp_pc) begin errors++; $display("FAIL drain_DecPC i=%0d: got %h expected %h", i, DecPC, exp_pc); end
    end
  endtask

  task automatic test_jump();
    do_reset();
    bj_pc = 32'h10;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (instEn !== 1'b0) begin errors++; $display("FAIL bj_instEn: got %b expected 0", instEn); end
    checks++; if (DecPC !== 32'h10) begin errors++; $display("FAIL bj_DecPC: got %h expected 00000010", DecPC); end
    checks++; if (DecInst !== 32'h6F) begin errors++; $display("FAIL bj_DecInst: got %h expected 0000006f", DecInst); end
    tick(); tick(); tick();
    checks++; if (instEn !== 1'b0) begin errors++; $display("FAIL bj_wait_instEn: got %b expected 0", instEn); end
    checks++; if (DecEn !== 1'b0) begin errors++; $display("FAIL bj_wait_DecEn: got %b expected 0", DecEn); end
    enJump = 1'b1; JumpAddr = 32'h100;
    tick();
    enJump = 1'b0;
    checks++; if (instEn !== 1'b1) begin errors++; $display("FAIL jump_instEn: got %b expected 1", instEn); end
    checks++; if (instAddr !== 32'h100) begin errors++; $display("FAIL jump_addr: got %h expected 00000100", instAddr); end
    checks++; if (DecEn !== 1'b0) begin errors++; $display("FAIL jump_empty: got %b expected 0", DecEn); end
    bj_pc = 32'hFFFF_FFF0;
    tick();
    checks++; if (DecPC !== 32'h100) begin errors++; $display("FAIL jump_DecPC: got %h expected 00000100", DecPC); end
    checks++; if (instAddr !== 32'h104) begin errors++; $display("FAIL jump_next_addr: got %h expected 00000104", instAddr); end
  endtask

  task automatic test_branch_discard();
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    resp_mode = 0;
    tick();
    checks++; if (instAddr !== 32'h20) begin errors++; $display("FAIL br_pending_addr: got %h expected 00000020", instAddr); end
    enBranch = 1'b1; BranchAddr = 32'h200;
    tick();
    enBranch = 1'b0;
    checks++; if (instEn !== 1'b1) begin errors++; $display("FAIL discard_instEn: got %b expected 1", instEn); end
    checks++; if (instAddr !== 32'h20) begin errors++; $display("FAIL discard_addr: got %h expected 00000020", instAddr); end
    checks++; if (DecEn !== 1'b0) begin errors++; $display("FAIL discard_flush: got %b expected 0", DecEn); end
    tick(); tick();
    checks++; if (instEn !== 1'b1) begin errors++; $display("FAIL discard_hold_instEn: got %b expected 1", instEn); end
    memInstOutEn = 1'b1; memInst = 32'h0000_006F;
    tick();
    memInstOutEn = 1'b0;
    checks++; if (instAddr !== 32'h200) begin errors++; $display("FAIL br_target_addr: got %h expected 00000200", instAddr); end
    checks++; if (instEn !== 1'b1) begin errors++; $display("FAIL br_target_instEn: got %b expected 1", instEn); end
    checks++; if (DecEn !== 1'b0) begin errors++; $display("FAIL br_dropped: got %b expected 0", DecEn); end
    resp_mode = 1;
    drive_resp();
    tick();
    checks++; if (DecPC !== 32'h200) begin errors++; $display("FAIL br_DecPC: got %h expected 00000200", DecPC); end
    checks++; if (DecInst !== mk_inst(32'h200)) begin errors++; $display("FAIL br_DecInst: got %h expected %h", DecInst, mk_inst(32'h200)); end
    checks++; if (instAddr !== 32'h204) begin errors++; $display("FAIL br_next_addr: got %h expected 00000204", instAddr); end
  endtask

  task automatic test_redirect_priority();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    stall = 1'b1;
    enJump = 1'b1; JumpAddr = 32'h300;
    enBranch = 1'b1; BranchAddr = 32'h400;
    tick();
    enJump = 1'b0; enBranch = 1'b0; stall = 1'b0;
    checks++; if (instAddr !== 32'h300) begin errors++; $display("FAIL both_addr: got %h expected 00000300", instAddr); end
    checks++; if (DecEn !== 1'b0) begin errors++; $display("FAIL both_flush: got %b expected 0", DecEn); end
    tick();
    checks++; if (DecPC !== 32'h300) begin errors++; $display("FAIL both_DecPC: got %h expected 00000300", DecPC); end
    checks++; if (instAddr !== 32'h304) begin errors++; $display("FAIL both_next_addr: got %h expected 00000304", instAddr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (instEn !== 1'b0) begin errors++; $display("FAIL arst_instEn: got %b expected 0", instEn); end
    checks++; if (instAddr !== 32'h0) begin errors++; $display("FAIL arst_instAddr: got %h expected 00000000", instAddr); end
    checks++; if (DecEn !== 1'b0) begin errors++; $display("FAIL arst_DecEn: got %b expected 0", DecEn); end
    checks++; if (DecPC !== 32'h0) begin errors++; $display("FAIL arst_DecPC: got %h expected 00000000", DecPC); end
    @(negedge clk);
    rst = 1'b0;
    hit = 1'b0;
    tick();
    checks++; if (instEn !== 1'b1) begin errors++; $display("FAIL arst_restart_instEn: got %b expected 1", instEn); end
    checks++; if (instAddr !== 32'h0) begin errors++; $display("FAIL arst_restart_addr: got %h expected 00000000", instAddr); end
    tick();
    checks++; if (DecPC !== 32'h0 || DecEn !== 1'b1) begin errors++; $display("FAIL arst_restart_DecPC: got %h/%b expected 00000000/1", DecPC, DecEn); end
    checks++; if (instAddr !== 32'h4) begin errors++; $display("FAIL arst_restart_next: got %h expected 00000004", instAddr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hit_priority();
    test_stall();
    test_jump();
    test_branch_discard();
    test_redirect_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL expose parameters, one per line:
- ADDR_W, 32, instruction address width
- INST_W, 32, instruction width
- QDEPTH, 4, queue entries (power of 2, 2..16)
- PC_STEP, 4, sequential PC increment
- RESET_PC, 0, first fetch address

REQ-002 The block SHALL expose ports, one per line:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  decoder not accepting this cycle
- enJump  in  1  jump redirect valid
- JumpAddr  in  ADDR_W  jump target
- enBranch  in  1  branch redirect valid
- BranchAddr  in  ADDR_W  branch target
- DecEn  out  1  queue head valid to decoder
- DecPC  out  ADDR_W  head PC
- DecInst  out  INST_W  head instruction
- instEn  out  1  fetch request outstanding (level)
- instAddr  out  ADDR_W  fetch request address
- hit  in  1  cache returns the outstanding request this cycle
- cacheInst  in  INST_W  cache data
- memInstOutEn  in  1  memory returns the outstanding request this cycle
- memInst  in  INST_W  memory data

Function
REQ-003 The block SHALL hold a FIFO of QDEPTH {PC, inst} entries with count width clog2(QDEPTH)+1; pointers SHALL wrap modulo QDEPTH.
REQ-004 A response SHALL be taken from cacheInst when hit=1, else from memInst when memInstOutEn=1; hit SHALL win if both are high.
REQ-005 At most one request SHALL be outstanding; instEn SHALL stay high from issue until the cycle a response arrives.
REQ-006 A new request SHALL issue on the clock edge after a response (or from IDLE) only when count after this cycle's enqueue/dequeue is < QDEPTH; the address SHALL be the last enqueued PC + PC_STEP (mod 2^ADDR_W).
REQ-007 States SHALL be IDLE, RUN, WAIT_BJ and DISCARD:
- IDLE -> RUN one cycle after reset, issuing RESET_PC
- RUN -> WAIT_BJ when an enqueued inst has bit 6 set
- WAIT_BJ -> RUN on redirect
- DISCARD -> RUN when the stale response arrives
REQ-008 In WAIT_BJ, no request SHALL issue and instEn SHALL be 0.
REQ-009 On redirect (enJump has priority over enBranch), the queue SHALL flush that edge, including any same-cycle enqueue.
- Request outstanding with no response this cycle: SHALL enter DISCARD, drop the next response, then issue the target.
- Otherwise: SHALL issue the target next cycle in RUN.
REQ-010 DecEn SHALL equal (count != 0); DecPC/DecInst SHALL show the head; dequeue SHALL occur when DecEn=1 and stall=0.
REQ-011 Simultaneous enqueue and dequeue when full SHALL be legal and keep count = QDEPTH.
REQ-012 A redirect arriving in the same cycle as a dequeue SHALL still consume the head (decoder accepted it).
REQ-013 Enqueue SHALL be suppressed while count = QDEPTH without a dequeue; REQ-006 guarantees this never drops data.

Reset
REQ-014 While rst=1 (asynchronously):
- state SHALL be IDLE
- count, pointers, instEn, DecEn SHALL be 0
- instAddr SHALL be RESET_PC
- DecPC and DecInst SHALL be 0
REQ-015 Reset asserted mid-request SHALL abandon the request with no DISCARD.

Configuration
REQ-016 With FETCH_BYPASS_EN defined, a response arriving while count=0, stall=0 and no redirect SHALL drive DecEn/DecPC/DecInst combinationally in the same cycle without enqueuing (zero-latency path).
REQ-017 Without FETCH_BYPASS_EN, every response SHALL be enqueued, giving one cycle minimum response-to-DecEn latency.

Verification
REQ-018 Reset release, cache hits every cycle, stall=0 -> instAddr sequence 0,4,8,C…; DecPC follows with 1-cycle latency (0 with FETCH_BYPASS_EN).
REQ-019 stall=1 for 10 cycles, QDEPTH=4, hits -> exactly 4 entries queued, instEn low, no lost or duplicated PCs after release.
REQ-020 Enqueue inst 0x0000006F at PC 0x10 -> WAIT_BJ, instEn=0; enJump with JumpAddr=0x100 -> next request 0x100, queue empty.
REQ-021 enBranch=1 (BranchAddr 0x200) while memory request at 0x20 is outstanding; memInstOutEn 3 cycles later -> that data discarded, then request 0x200 issued.
REQ-022 enJump and enBranch in the same cycle (0x300 / 0x400) -> 0x300 fetched.
REQ-023 rst pulsed asynchronously mid-request -> outputs reset immediately; fetch restarts at RESET_PC.
